// File: rtl/fpadd_result_finalize.sv
// fpadd_result_finalize: last stage of the FP adder's special-case path.
// It picks the final 64-bit result and the per-op flags, and keeps sticky
// flags plus a saturating count of invalid operations.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   A, B, op_type         operands and opcode
//   Ztype, Invalid,       classification results from the adder
//   Denorm
//   Sum, Ovf, Unf, Inx    rounded result and flags from the normal path
//   rm                    rounding mode (00 RNE, 01 RZ, 10 RDN, 11 RUP)
//   out_valid / out_ready output handshake
//   Result, Flags         final result and flags {NV, OF, UF, NX, DN}
//   flag_clr              clears StickyFlags and InvCount
//   StickyFlags, InvCount history of accepted outputs
module fpadd_result_finalize #(
    parameter int          CNT_W        = 16,
    parameter logic [63:0] QNAN_DEFAULT = 64'h7FF8000000000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      A,
    input  logic [63:0]      B,
    input  logic [2:0]       op_type,
    input  logic [3:0]       Ztype,
    input  logic             Invalid,
    input  logic             Denorm,
    input  logic [63:0]      Sum,
    input  logic             Ovf,
    input  logic             Unf,
    input  logic             Inx,
    input  logic [1:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      Result,
    output logic [4:0]       Flags,
    input  logic             flag_clr,
    output logic [4:0]       StickyFlags,
    output logic [CNT_W-1:0] InvCount
);

    localparam logic [63:0] NEG_INF  = 64'hFFF0000000000000;
    localparam logic [63:0] POS_INF  = 64'h7FF0000000000000;
    localparam logic [63:0] POS_ZERO = 64'h0000000000000000;
    localparam logic [63:0] NEG_ZERO = 64'h8000000000000000;

    // Stage-1 bundle. Only the add/sub decode of op_type is needed later.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        add_sub;
        logic [3:0]  ztype;
        logic        invalid;
        logic        denorm;
        logic [63:0] sum;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic [1:0]  rm;
    } s1_t;

    s1_t             s1_q;
    s1_t             s1_d;
    logic            s1_valid;
    logic            s2_valid;
    logic [63:0]     result_q;
    logic [4:0]      flags_q;
    logic [4:0]      sticky_q;
    logic [CNT_W-1:0] inv_cnt_q;

    logic            accept;
    logic            s2_load;
    logic            out_hs;

    logic            unused_op;

    // Stage-1 decode results
    logic            a_nan;
    logic            b_nan;
    logic            z_norm;
    logic            z_qnan;
    logic            z_ninf;
    logic            z_pinf;
    logic            z_pzero;
    logic            z_rzero;
    logic            z_nzero;
    logic            z_rsvd;
    logic            z_cvt;
    logic            pass_flags;
    logic [63:0]     sel_result;
    logic [4:0]      sel_flags;

    // Sticky/counter next-state helpers
    logic [4:0]      sticky_base;
    logic [CNT_W-1:0] cnt_base;

    // op_type[0] does not distinguish add/sub from the other opcodes.
    assign unused_op = op_type[0];

    // Handshake
    assign accept   = in_valid & in_ready;
    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign out_hs   = s2_valid & out_ready;
    assign in_ready = ~s1_valid | ~s2_valid | out_ready;

    always_comb begin
        s1_d         = '0;
        s1_d.a       = A;
        s1_d.b       = B;
        s1_d.add_sub = ~op_type[2] & ~op_type[1];
        s1_d.ztype   = Ztype;
        s1_d.invalid = Invalid;
        s1_d.denorm  = Denorm;
        s1_d.sum     = Sum;
        s1_d.ovf     = Ovf;
        s1_d.unf     = Unf;
        s1_d.inx     = Inx;
        s1_d.rm      = rm;
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 1 decode
    always_comb begin
        a_nan   = (&s1_q.a[62:52]) & (|s1_q.a[51:0]);
        b_nan   = (&s1_q.b[62:52]) & (|s1_q.b[51:0]);
        z_cvt   = s1_q.ztype[3];
        z_norm  = s1_q.ztype == 4'b0000;
        z_qnan  = s1_q.ztype == 4'b0001;
        z_ninf  = s1_q.ztype == 4'b0010;
        z_pinf  = s1_q.ztype == 4'b0011;
        z_pzero = s1_q.ztype == 4'b0100;
        z_rzero = s1_q.ztype == 4'b0101;
        z_nzero = s1_q.ztype == 4'b0110;
        z_rsvd  = s1_q.ztype == 4'b0111;

        sel_result = s1_q.sum;
        unique case (1'b1)
            z_norm, z_cvt, z_rsvd: begin
                sel_result = s1_q.sum;
            end
            z_qnan: begin
                // Payload comes from A first, then B (add/sub only).
                if (a_nan) begin
                    sel_result     = s1_q.a;
                    sel_result[51] = 1'b1;
                end else if (s1_q.add_sub && b_nan) begin
                    sel_result     = s1_q.b;
                    sel_result[51] = 1'b1;
                end else begin
                    sel_result = QNAN_DEFAULT;
                end
            end
            z_ninf:  sel_result = NEG_INF;
            z_pinf:  sel_result = POS_INF;
            z_pzero: sel_result = POS_ZERO;
            z_rzero: begin
                // Exact zero sum: sign follows the rounding direction.
                sel_result = (s1_q.rm == 2'b10) ? NEG_ZERO : POS_ZERO;
            end
            z_nzero: sel_result = NEG_ZERO;
            default: sel_result = s1_q.sum;
        endcase

        // Normal-path OF/UF/NX only describe results that came from Sum.
        pass_flags = z_norm | z_cvt;
        sel_flags  = {s1_q.invalid,
                      s1_q.ovf & pass_flags,
                      s1_q.unf & pass_flags,
                      s1_q.inx & pass_flags,
                      s1_q.denorm};
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                result_q <= sel_result;
                flags_q  <= sel_flags;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // A clear wipes history first; a coincident handshake is then applied.
    always_comb begin
        sticky_base = flag_clr ? 5'b0 : sticky_q;
        cnt_base    = flag_clr ? '0 : inv_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q  <= '0;
            inv_cnt_q <= '0;
        end else if (flag_clr | out_hs) begin
            sticky_q <= sticky_base | (out_hs ? flags_q : 5'b0);
            if (out_hs && flags_q[4] && !(&cnt_base)) begin
                inv_cnt_q <= cnt_base + CNT_W'(1);
            end else begin
                inv_cnt_q <= cnt_base;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign Result      = result_q;
    assign Flags       = flags_q;
    assign StickyFlags = sticky_q;
    assign InvCount    = inv_cnt_q;

endmodule

// File: doc/fpadd_result_finalize.md
Name: fpadd_result_finalize

Overview:
- Back end of the FP adder's special-case classification.
- Consumes the per-operation classification (Ztype, Invalid, Denorm), the operands and the normal-path rounded sum. Produces the architectural 64-bit result and per-operation exception flags.
- Keeps a sticky exception status register and a saturating invalid-operation counter.
- Two-stage valid/ready pipeline between the adder datapath and the writeback port.

Parameters:
- CNT_W, 16, width of the saturating invalid-operation counter.
- QNAN_DEFAULT, 64'h7FF8000000000000, canonical quiet NaN returned when neither operand supplies a payload.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- A  in  64  operand 1 (IEEE double)
- B  in  64  operand 2 (IEEE double)
- op_type  in  3  function opcode; add_sub = ~op_type[2] & ~op_type[1]
- Ztype  in  4  result-type code from classification
- Invalid  in  1  invalid-operation exception
- Denorm  in  1  denormal-input flag
- Sum  in  64  normal-path rounded result
- Ovf  in  1  normal-path overflow
- Unf  in  1  normal-path underflow
- Inx  in  1  normal-path inexact
- rm  in  2  rounding mode: 00 RNE, 01 RZ, 10 RDN, 11 RUP
- out_valid  out  1  output transaction valid
- out_ready  in  1  consumer accepts output
- Result  out  64  final result
- Flags  out  5  per-op flags {NV, OF, UF, NX, DN}
- flag_clr  in  1  clear sticky flags and counter
- StickyFlags  out  5  OR of Flags over all accepted outputs since reset/clear
- InvCount  out  CNT_W  number of accepted outputs with NV=1, saturating

Behaviour:
- Reset (async, active-high) clears s1_valid, s2_valid, Result, Flags, StickyFlags and InvCount to 0.
  - in_ready is 1 during and after reset; out_valid is 0.
- Pipeline handshake:
  - Stage 1 register (s1) captures all inputs when in_valid & in_ready.
  - Stage 2 register (s2) drives the outputs.
  - s2 loads from s1 when s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | ~s2_valid | out_ready.
  - Latency is 2 cycles from accept to out_valid with no backpressure; throughput is 1 per cycle.
  - Outputs hold stable while out_valid & ~out_ready. No transaction is dropped or duplicated.
- Result select, decoded in stage 1 and registered into s2:
  - 0000 normal: Sum.
  - 0001 quiet NaN, in priority order:
    - A is NaN: A with bit 51 forced to 1.
    - else add_sub and B is NaN: B with bit 51 forced to 1.
    - else QNAN_DEFAULT.
  - 0010: 64'hFFF0000000000000 (-Inf).
  - 0011: 64'h7FF0000000000000 (+Inf).
  - 0100: +0.
  - 0101: +0, except -0 (64'h8000000000000000) when rm=10.
  - 0110: -0.
  - 1xxx: Sum (convert passthrough).
  - Any other code: Sum.
- Flags:
  - NV = Invalid.
  - DN = Denorm.
  - OF, UF and NX equal Ovf, Unf and Inx only when Ztype=0000 or Ztype[3]=1; otherwise they are 0.
- Sticky and counter, updated on the output handshake (out_valid & out_ready):
  - StickyFlags |= Flags.
  - InvCount increments if Flags[4]=1 and saturates at all-ones.
- flag_clr:
  - Alone: StickyFlags and InvCount become 0 next cycle.
  - Coincident with a handshake: StickyFlags becomes that transaction's Flags, and InvCount becomes 1 if NV else 0. The clear applies to prior history only.
  - flag_clr does not affect pipeline contents.
- Reset asserted mid-transaction discards both stages; no output is produced for in-flight data.

Test Plan:
- Normal back-to-back: 3 ops with Ztype=0000, Sum=3FF0000000000000/4000000000000000/4008000000000000, out_ready=1 -> Results appear on cycles 2,3,4 in order, out_valid continuous, Flags=0.
- NaN propagation: A=7FF0000000000001 (SNaN), Ztype=0001, Invalid=1 -> Result=7FF8000000000001, Flags=10000, InvCount=1.
  - Then A=3FF0000000000000, B=FFF4000000000000, op_type=001, Ztype=0001 -> Result=FFFC000000000000.
- Zero sign: Ztype=0101 with rm=00 -> 0000000000000000; same with rm=10 -> 8000000000000000; Ztype=0110 -> 8000000000000000.
- Backpressure: hold out_ready=0 for 4 cycles while driving 3 inputs -> in_ready drops after 2 accepted, Result stable. Release -> all 3 emerge in order, none lost.
- Flag masking and sticky: Ztype=0011 with Ovf=Inx=1 -> Flags=00000. Ztype=0000 with Inx=1 -> Flags=00010, StickyFlags=00010.
  - flag_clr alone -> StickyFlags=0.
  - flag_clr coincident with an NV handshake -> StickyFlags=10000, InvCount=1.
- Saturation and reset: preload InvCount to FFFF via CNT_W=16 traffic (or CNT_W=2 instance with 5 NV ops) -> stays at max.
  - Assert reset with both stages full -> out_valid=0 immediately, no later output.
